// File: rtl/ls_tile_burst.sv
// Burst load/store tile: one command drives 1..2^LEN_W memory beats between a PE port and memory.
// Loads land in a credit-protected response FIFO; stores pass straight through to memory.
module ls_tile_burst #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CTRL_W    = LEN_W + 2 * ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CTRL_W-1:0] cmd_ctrl,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              pe_out_valid,
  input  logic              pe_out_ready,
  output logic [DATA_W-1:0] pe_out_data,
  input  logic              pe_in_valid,
  output logic              pe_in_ready,
  input  logic [DATA_W-1:0] pe_in_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StLdWait, StStore} state_e;

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_base;
  logic [LEN_W-1:0]    r_len, r_beat;
  logic [CntW-1:0]     r_outst, r_count;
  logic [PtrW-1:0]     r_wptr, r_rptr;
  logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
  logic                r_err, r_done;

  logic w_cmd_hs, w_req_hs, w_ld_req_hs, w_last, w_credit;
  logic w_rsp_ok, w_push, w_pop, w_ld_done;

  assign w_cmd_hs    = cmd_valid & cmd_ready;
  assign w_req_hs    = mem_req_valid & mem_req_ready;
  assign w_ld_req_hs = w_req_hs & (r_state == StLoad);
  assign w_last      = (r_beat == r_len);
  // Credit: every in-flight read already owns a FIFO slot, so the FIFO can never overflow.
  assign w_credit    = ({1'b0, r_outst} + {1'b0, r_count}) < DepthC;
  assign w_rsp_ok    = mem_rsp_valid & (r_outst != '0);
  assign w_push      = w_rsp_ok;
  assign w_pop       = pe_out_valid & pe_out_ready;

  assign busy         = (r_state != StIdle);
  assign done         = r_done | w_ld_done;
  assign err          = r_err;
  assign pe_out_valid = (r_count != '0);
  assign pe_out_data  = pe_out_valid ? r_fifo[r_rptr] : '0;

  always_comb begin
    w_state_next  = r_state;
    cmd_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_wdata = '0;
    pe_in_ready   = 1'b0;
    w_ld_done     = 1'b0;
    mem_req_addr  = r_base + ADDR_W'(r_beat);
    unique case (r_state)
      StIdle: begin
        cmd_ready = ~reset;
        if (cmd_valid && !reset) w_state_next = cmd_ctrl[0] ? StStore : StLoad;
      end
      StLoad: begin
        mem_req_valid = w_credit;
        if (w_credit && mem_req_ready && w_last) w_state_next = StLdWait;
      end
      StLdWait: begin
        if (r_outst == '0) begin
          w_ld_done    = 1'b1;
          w_state_next = StIdle;
        end
      end
      StStore: begin
        mem_req_valid = pe_in_valid;
        pe_in_ready   = mem_req_ready;
        mem_req_we    = 1'b1;
        mem_req_wdata = pe_in_data;
        if (pe_in_valid && mem_req_ready && w_last) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_outst <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == StStore) && w_req_hs && w_last;
      if (w_cmd_hs) begin
        r_base <= cmd_ctrl[1 +: ADDR_W] + cmd_ctrl[1 + ADDR_W +: ADDR_W];
        r_len  <= cmd_ctrl[CTRL_W-1 -: LEN_W];
        r_beat <= '0;
      end else if (w_req_hs) begin
        r_beat <= r_beat + 1'b1;
      end
      if (mem_rsp_valid && (r_outst == '0)) r_err <= 1'b1;
      case ({w_ld_req_hs, w_rsp_ok})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= mem_rsp_rdata;
  end

endmodule

// File: doc/ls_tile_burst.md
Name: ls_tile_burst

Overview:
Parametrised load/store tile for the PE array. It is the successor to the single-word LS tile: it accepts one command per transaction and executes a burst of 1..2^LEN_W words. It sits between one PE port and the tile's memory port. Loads are buffered in a credit-protected response FIFO; stores pass from the PE to memory under a valid/ready handshake. Command, memory-request, PE-in and PE-out interfaces all use valid/ready handshakes.

Parameters:
DATA_W, 32, data word width
ADDR_W, 6, memory word-address width (64-entry memory)
LEN_W, 4, burst length field width; number of beats = len+1
FIFO_DEPTH, 4, load-data FIFO entries (power of 2, >=2)
CTRL_W (localparam) = LEN_W+2*ADDR_W+1; ctrl = {len, offset, addr, op}, where op=0 is load (memory->PE) and op=1 is store (PE->memory)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
cmd_valid  in  1  command present
cmd_ready  out  1  tile can accept a command (high only in IDLE)
cmd_ctrl  in  CTRL_W  command word
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=write, 0=read
mem_req_addr  out  ADDR_W  word address
mem_req_wdata  out  DATA_W  store data
mem_rsp_valid  in  1  read data valid; arrives in order, cannot be stalled
mem_rsp_rdata  in  DATA_W  read data
pe_out_valid  out  1  load data available to PE
pe_out_ready  in  1  PE consumes load data
pe_out_data  out  DATA_W  FIFO head
pe_in_valid  in  1  PE store data valid
pe_in_ready  out  1  tile accepts store data
pe_in_data  in  DATA_W  store data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on transaction completion
err  out  1  sticky: unexpected mem_rsp_valid

Behaviour:
- Reset values: all outputs 0 and state=IDLE. FIFO, outstanding counter, beat counter and err are cleared. cmd_ready rises combinationally once reset deasserts.
- Reset mid-burst: the transaction is abandoned with no done pulse. Responses to requests issued before reset count as unexpected (err=1, data dropped).
- States: IDLE, LOAD, LDWAIT, STORE.
- IDLE: cmd_ready=1. On cmd_valid, latch the fields, set beat=0, base=addr+offset (mod 2^ADDR_W), and go to LOAD or STORE. The first request can appear in the next cycle.
- Address for each beat = base+beat, truncated to ADDR_W (wraps 63->0).
- LOAD: mem_req_valid=1, we=0, gated by a credit check: outstanding + fifo_count < FIFO_DEPTH. On handshake: beat++, outstanding++. After the last beat's handshake, go to LDWAIT.
- LDWAIT: no requests. When outstanding reaches 0, pulse done and go to IDLE. If the last response arrives while the last request is still being handshaken (single-beat case), done pulses on the cycle outstanding becomes 0 in LDWAIT.
- Response: when mem_rsp_valid and outstanding>0, push to the FIFO and decrement outstanding. If outstanding==0, drop the data and set err.
- Simultaneous request handshake and response in one cycle: outstanding is unchanged.
- FIFO: registered. Data pushed in cycle R gives pe_out_valid in R+1. Pop on pe_out_valid & pe_out_ready. Simultaneous push and pop is legal at any occupancy, including full. The credit rule guarantees no overflow. FIFO contents persist after done and drain independently of later commands.
- STORE: combinational pass-through with zero latency. mem_req_valid=pe_in_valid, pe_in_ready=mem_req_ready, we=1, wdata=pe_in_data. On handshake beat++. When the last beat handshakes, pulse done in the next cycle and go to IDLE.
- Outside STORE, pe_in_ready=0. Outside LOAD/STORE, mem_req_valid=0.
- Outputs are stable while valid is high and ready is low.
- Throughput: one beat per cycle when unstalled and credits are available.

Test Plan:
- Load with addr=5, offset=3, len=3, memory latency 2, pe_out_ready=1 -> requests to 8,9,10,11 on consecutive cycles; 4 data words reach the PE in order; one done pulse; err=0.
- Wrap-around: load addr=62, offset=0, len=3 -> addresses 62,63,0,1.
- Backpressure: load len=7, pe_out_ready=0 -> exactly 4 requests issue, then stall. Raising ready resumes issue; all 8 words are delivered with no loss; FIFO never exceeds 4 entries.
- Store addr=10, offset=0, len=2, with pe_in_valid toggled and mem_req_ready stalled 2 cycles -> writes of the PE words to 10,11,12 with matching data; done pulses one cycle after the third handshake; pe_in_ready=0 in IDLE.
- Unexpected response in IDLE -> err=1 and stays 1; FIFO unchanged.
- Assert reset during beat 2 of a len=5 load -> all outputs 0, FIFO empty, no done pulse. A late response sets err=1; a new command is accepted normally.
